write_request_encoder32: RTL



---
 rtl/regfile_pkg.sv | 23 ++
 rtl/lsb_priority_encoder32.sv | 22 ++
 rtl/write_request_encoder32.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes, FSM state type and helpers for the register-file write-request path.
package regfile_pkg;

  localparam int unsigned N = 32;
  localparam int unsigned W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } state_e;

  // Number of set bits in a request mask; W+1 bits so that an all-ones mask counts to N.
  function automatic logic [W:0] popcount(input logic [N-1:0] vec);
    logic [W:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt = cnt + (W+1)'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lsb_priority_encoder32.sv
// Combinational lowest-set-bit priority encoder: index of the lowest set bit plus an any flag.
module lsb_priority_encoder32
  import regfile_pkg::*;
(
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_request_encoder32.sv
// Serialises a multi-hot write-request mask into one {sel, en} grant per cycle, lowest
// index first, with a valid/ack handshake towards the register-file write decoder.
module write_request_encoder32
  import regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_vec,
  input  logic         req_load,
  input  logic         ack,
  output logic [W-1:0] sel,
  output logic         en,
  output logic         busy,
  output logic [W:0]   remaining,
  output logic         done
);

  state_e       state_q;
  logic [N-1:0] pending_q;
  logic [W:0]   remaining_q;
  logic         en_q;
  logic         busy_q;
  logic         done_q;

  logic [W-1:0] lsb_idx;
  logic         lsb_any;

  lsb_priority_encoder32 u_lsb_enc (
    .req (pending_q),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  // Batch FSM: pending mask, outstanding count and registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      remaining_q <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_load) begin
            if (req_vec != '0) begin
              pending_q   <= req_vec;
              remaining_q <= popcount(req_vec);
              en_q        <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= StActive;
            end else begin
              // An empty batch still reports completion.
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StActive: begin
          if (ack) begin
            pending_q   <= pending_q & ~(N'(1) << lsb_idx);
            remaining_q <= remaining_q - (W+1)'(1);
            if (remaining_q == (W+1)'(1)) begin
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // sel depends only on registered state, so there is no input-to-output path.
  always_comb begin
    sel = (en_q && lsb_any) ? lsb_idx : '0;
  end

  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule
